pe_shift_out: RTL and testbench

PE_SHIFT_OUT -- requirements
Module: pe_shift_out

---
 rtl/pe_pkg.sv | 21 ++
 rtl/pe_hold_buffer.sv | 50 +++++
 rtl/pe_shift_out.sv | 209 ++++++++++++++++++++
 tb/tb_pe_shift_out.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_pkg
// Purpose  : Shared types and constants for the pe_shift_out serializer.
//            Holds the serializer state encoding and the default word width.
// Revision : 1.0 - initial release
// ============================================================================
package pe_pkg;

  // Default width of the parallel word / serial payload.
  localparam int c_DEFAULT_DATA_W = 8;

  // Serializer states. ST_PAR is only reachable when parity is compiled in.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } pe_state_t;

endpackage
`default_nettype wire

// File: rtl/pe_hold_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pe_hold_buffer
// Purpose  : One-entry holding register that parks a word accepted while the
//            shifter is still busy with the previous frame.
// Ports    : clk      - clock, rising edge
//            rst      - synchronous reset, active low (empties the buffer)
//            i_load   - capture i_data and mark the buffer full
//            i_data   - word to capture
//            i_drain  - buffer contents consumed this edge, mark empty
//            o_data   - buffered word
//            o_full   - buffer holds a word
// Revision : 1.0 - initial release
// ============================================================================
module pe_hold_buffer
  import pe_pkg::*;
#(
  parameter int DATA_W = c_DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_drain,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full
);

  logic [DATA_W-1:0] r_data;
  logic              r_full;

  // The parent only loads while the buffer is empty and only drains while it
  // is full, so load and drain never coincide; load is given priority anyway.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (i_load) begin
      r_data <= i_data;
      r_full <= 1'b1;
    end else if (i_drain) begin
      r_full <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule
`default_nettype wire

// File: rtl/pe_shift_out.sv
`default_nettype none
// ============================================================================
// Module   : pe_shift_out
// Purpose  : Parallel-to-serial frame transmitter with a one-word holding
//            buffer so back-to-back words stream out without gaps.
// Params   : DATA_W    - payload width (>= 2)
//            MSB_FIRST - 0: bit 0 sent first, 1: bit DATA_W-1 sent first
// Macro    : PE_SHIFT_OUT_PARITY_EN - append an even-parity bit to each frame
// Ports    : clk       - clock, rising edge
//            rst       - synchronous reset, active low
//            in        - parallel word
//            in_valid  - word on in is offered
//            in_ready  - word can be accepted this cycle
//            ser_out   - serial bit (registered, 0 when idle)
//            ser_valid - ser_out carries a frame bit (registered)
//            ser_last  - final bit of the frame (registered)
//            busy      - frame in progress or word buffered
// Revision : 1.0 - initial release
// ============================================================================
module pe_shift_out
  import pe_pkg::*;
#(
  parameter int DATA_W    = c_DEFAULT_DATA_W,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_last,
  output logic              busy
);

  localparam int            CW         = $clog2(DATA_W);
  localparam logic [CW-1:0] c_LAST_IDX = CW'(DATA_W - 1);
`ifndef PE_SHIFT_OUT_PARITY_EN
  localparam logic [CW-1:0] c_PENULT_IDX = CW'(DATA_W - 2);
`endif

  // The shifter is kept pre-advanced: when a bit is placed on ser_out, the
  // register already holds the remaining bits with the next one at the head.
  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  pe_state_t         r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_shreg, w_shreg_nxt;
  logic              r_ser_out, w_ser_out_nxt;
  logic              r_ser_valid, w_ser_valid_nxt;
  logic              r_ser_last, w_ser_last_nxt;
`ifdef PE_SHIFT_OUT_PARITY_EN
  logic              r_par, w_par_nxt;
`endif

  logic              w_buf_full;
  logic [DATA_W-1:0] w_buf_data;
  logic              w_xfer;
  logic              w_frame_end;
  logic              w_start_direct;
  logic              w_buf_load;
  logic              w_buf_drain;
  logic              w_start;
  logic [DATA_W-1:0] w_start_word;

  assign in_ready = ~w_buf_full & rst;
  assign w_xfer   = in_valid & in_ready;

  // Edge on which the last bit of the current frame is retired.
`ifdef PE_SHIFT_OUT_PARITY_EN
  assign w_frame_end = (r_state == ST_PAR);
`else
  assign w_frame_end = (r_state == ST_SHIFT) && (r_cnt == c_LAST_IDX);
`endif

  // A word offered when the shifter is free (idle, or finishing its frame
  // this very edge) goes straight into the shifter; otherwise it is parked.
  // A drain only happens while the buffer is full, which holds in_ready low,
  // so a direct start and a drain can never coincide.
  assign w_start_direct = w_xfer & ((r_state == ST_IDLE) | w_frame_end);
  assign w_buf_load     = w_xfer & ~w_start_direct;
  assign w_buf_drain    = w_frame_end & w_buf_full;
  assign w_start        = w_start_direct | w_buf_drain;
  assign w_start_word   = w_buf_drain ? w_buf_data : in;

  pe_hold_buffer #(
    .DATA_W (DATA_W)
  ) u_hold_buffer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_buf_load),
    .i_data  (in),
    .i_drain (w_buf_drain),
    .o_data  (w_buf_data),
    .o_full  (w_buf_full)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (r_cnt == c_LAST_IDX) begin
`ifdef PE_SHIFT_OUT_PARITY_EN
          w_state_nxt = ST_PAR;
`else
          w_state_nxt = w_start ? ST_SHIFT : ST_IDLE;
`endif
        end
      end
`ifdef PE_SHIFT_OUT_PARITY_EN
      ST_PAR: begin
        w_state_nxt = w_start ? ST_SHIFT : ST_IDLE;
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output / datapath next values. Serial outputs default to 0 so ser_out
  // and ser_last are low whenever ser_valid is low.
  always_comb begin
    w_cnt_nxt       = r_cnt;
    w_shreg_nxt     = r_shreg;
    w_ser_out_nxt   = 1'b0;
    w_ser_valid_nxt = 1'b0;
    w_ser_last_nxt  = 1'b0;
`ifdef PE_SHIFT_OUT_PARITY_EN
    w_par_nxt       = r_par;
`endif
    if (w_start) begin
      w_cnt_nxt       = '0;
      w_shreg_nxt     = advance(w_start_word);
      w_ser_out_nxt   = head_bit(w_start_word);
      w_ser_valid_nxt = 1'b1;
`ifdef PE_SHIFT_OUT_PARITY_EN
      w_par_nxt       = ^w_start_word;
`endif
    end else if (r_state == ST_SHIFT) begin
      if (r_cnt != c_LAST_IDX) begin
        w_cnt_nxt       = r_cnt + 1'b1;
        w_shreg_nxt     = advance(r_shreg);
        w_ser_out_nxt   = head_bit(r_shreg);
        w_ser_valid_nxt = 1'b1;
`ifndef PE_SHIFT_OUT_PARITY_EN
        w_ser_last_nxt  = (r_cnt == c_PENULT_IDX);
`endif
      end
`ifdef PE_SHIFT_OUT_PARITY_EN
      else begin
        w_ser_out_nxt   = r_par;
        w_ser_valid_nxt = 1'b1;
        w_ser_last_nxt  = 1'b1;
      end
`endif
    end
  end

  // Datapath and registered serial outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_shreg     <= '0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_ser_last  <= 1'b0;
`ifdef PE_SHIFT_OUT_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_shreg     <= w_shreg_nxt;
      r_ser_out   <= w_ser_out_nxt;
      r_ser_valid <= w_ser_valid_nxt;
      r_ser_last  <= w_ser_last_nxt;
`ifdef PE_SHIFT_OUT_PARITY_EN
      r_par       <= w_par_nxt;
`endif
    end
  end

  assign ser_out   = r_ser_out;
  assign ser_valid = r_ser_valid;
  assign ser_last  = r_ser_last;
  assign busy      = (r_state != ST_IDLE) | w_buf_full;

endmodule
`default_nettype wire

// File: tb/tb_pe_shift_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_shift_out
// Purpose  : Self-checking bench for pe_shift_out. Two instances (LSB-first
//            and MSB-first) share one stimulus stream; a queue-based frame
//            model predicts every output each cycle, and directed vectors
//            and sequences cover the documented corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_shift_out;

`ifdef PE_SHIFT_OUT_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;

  logic l_ready, l_out, l_valid, l_last, l_busy;
  logic m_ready, m_out, m_valid, m_last, m_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pe_shift_out #(.DATA_W(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .in(din), .in_valid(din_valid), .in_ready(l_ready),
    .ser_out(l_out), .ser_valid(l_valid), .ser_last(l_last), .busy(l_busy));

  pe_shift_out #(.DATA_W(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .in(din), .in_valid(din_valid), .in_ready(m_ready),
    .ser_out(m_out), .ser_valid(m_valid), .ser_last(m_last), .busy(m_busy));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bit k of the frame carrying word w.
  function automatic logic fbit(input logic [7:0] w, input int k, input bit msb);
    if (k < 8) return msb ? w[7-k] : w[k];
    return ^w;
  endfunction

  // ---------------- reference model: queue of accepted words ----------------
  logic [7:0] mq[$];
  int         midx   = 0;
  bit         chk_en = 1'b0;
  bit         mrdy;

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      midx   = 0;
      chk_en = 1'b1;
    end else begin
      mrdy = (mq.size() < 2);
      if (mq.size() > 0) begin
        midx++;
        if (midx == FL) begin
          void'(mq.pop_front());
          midx = 0;
        end
      end
      if (din_valid && mrdy) mq.push_back(din);
    end
  end

  logic ev, er, el, em, elast;
  always @(negedge clk) begin
    if (chk_en) begin
      ev    = (mq.size() > 0);
      er    = rst && (mq.size() < 2);
      el    = ev ? fbit(mq[0], midx, 1'b0) : 1'b0;
      em    = ev ? fbit(mq[0], midx, 1'b1) : 1'b0;
      elast = ev && (midx == FL - 1);
      check("model_lsb", {27'd0, l_ready, l_busy, l_valid, l_out, l_last},
                         {27'd0, er, ev, ev, el, elast});
      check("model_msb", {27'd0, m_ready, m_busy, m_valid, m_out, m_last},
                         {27'd0, er, ev, ev, em, elast});
    end
  end

  // ---------------- directed vectors ----------------
  // lsb/msb hold the expected payload in transmission order, leftmost first.
  typedef struct {
    logic [7:0] w;
    logic [7:0] lsb;
    logic [7:0] msb;
    logic       par;
  } vec_t;

  vec_t tbl[6];

  task automatic run_vec(input vec_t v);
    logic [8:0] sl, sm, ls, exl, exm;
    int         nv;
    sl = '0; sm = '0; ls = '0; nv = 0;
    @(posedge clk); #2;
    for (int n = 0; n < 100 && !l_ready; n++) begin
      @(posedge clk); #2;
    end
    check("vec_ready", {31'd0, l_ready}, 32'd1);
    din = v.w; din_valid = 1'b1;
    @(posedge clk);
    #2 din_valid = 1'b0;
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      sl = {sl[7:0], l_out};
      sm = {sm[7:0], m_out};
      ls = {ls[7:0], l_last};
      if (l_valid && m_valid) nv++;
    end
`ifdef PE_SHIFT_OUT_PARITY_EN
    exl = {v.lsb, v.par};
    exm = {v.msb, v.par};
`else
    exl = {1'b0, v.lsb};
    exm = {1'b0, v.msb};
`endif
    check("vec_lsb_bits", {23'd0, sl}, {23'd0, exl});
    check("vec_msb_bits", {23'd0, sm}, {23'd0, exm});
    check("vec_valid_last", {nv[22:0], ls}, {FL[22:0], 9'd1});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] sl, sm, ls, exl, exm, exs;
    logic [7:0]  w3[3];
    int          nv;

    tbl[0] = '{w: 8'hA5, lsb: 8'b1010_0101, msb: 8'b1010_0101, par: 1'b0};
    tbl[1] = '{w: 8'h01, lsb: 8'b1000_0000, msb: 8'b0000_0001, par: 1'b1};
    tbl[2] = '{w: 8'h80, lsb: 8'b0000_0001, msb: 8'b1000_0000, par: 1'b1};
    tbl[3] = '{w: 8'h07, lsb: 8'b1110_0000, msb: 8'b0000_0111, par: 1'b1};
    tbl[4] = '{w: 8'h1E, lsb: 8'b0111_1000, msb: 8'b0001_1110, par: 1'b0};
    tbl[5] = '{w: 8'h00, lsb: 8'b0000_0000, msb: 8'b0000_0000, par: 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {22'd0, l_ready, l_busy, l_valid, l_out, l_last,
                                 m_ready, m_busy, m_valid, m_out, m_last}, 32'd0);
    @(posedge clk); #2 rst = 1'b1;
    #1 check("ready_after_reset", {30'd0, l_ready, m_ready}, 32'd3);

    // Table-driven single frames
    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Back-to-back 0x01 then 0x80 with in_valid held
    sl = '0; sm = '0; ls = '0; nv = 0;
    @(posedge clk); #2;
    fork
      begin
        din = 8'h01; din_valid = 1'b1;
        @(posedge clk); #2 din = 8'h80;
        @(posedge clk); #2 din_valid = 1'b0;
      end
      begin
        @(posedge clk);
        for (int k = 0; k < 2 * FL; k++) begin
          @(negedge clk);
          sl = {sl[30:0], l_out};
          sm = {sm[30:0], m_out};
          ls = {ls[30:0], l_last};
          if (l_valid && m_valid) nv++;
        end
      end
    join
`ifdef PE_SHIFT_OUT_PARITY_EN
    exl = {14'd0, 8'b1000_0000, 1'b1, 8'b0000_0001, 1'b1};
    exm = {14'd0, 8'b0000_0001, 1'b1, 8'b1000_0000, 1'b1};
    exs = {14'd0, 9'b0_0000_0001, 9'b0_0000_0001};
`else
    exl = {16'd0, 8'b1000_0000, 8'b0000_0001};
    exm = {16'd0, 8'b0000_0001, 8'b1000_0000};
    exs = {16'd0, 8'b0000_0001, 8'b0000_0001};
`endif
    check("b2b_lsb_bits", sl, exl);
    check("b2b_msb_bits", sm, exm);
    check("b2b_last", ls, exs);
    check("b2b_no_gap", nv, 2 * FL);

    // Three words offered back-to-back while busy
    w3[0] = 8'h3C; w3[1] = 8'hC3; w3[2] = 8'h5A;
    sl = '0; sm = '0; nv = 0;
    repeat (3) @(posedge clk);
    #2;
    fork
      begin
        for (int j = 0; j < 3; j++) begin
          din = w3[j]; din_valid = 1'b1;
          for (int n = 0; n < 100 && !l_ready; n++) begin
            @(posedge clk); #2;
          end
          @(posedge clk); #2;
        end
        din_valid = 1'b0;
      end
      begin
        @(posedge clk);
        for (int k = 0; k < 3 * FL; k++) begin
          @(negedge clk);
          sl = {sl[30:0], l_out};
          sm = {sm[30:0], m_out};
          if (l_valid && m_valid) nv++;
        end
      end
    join
    exl = '0; exm = '0;
    for (int j = 0; j < 3; j++)
      for (int k = 0; k < FL; k++) begin
        exl = {exl[30:0], fbit(w3[j], k, 1'b0)};
        exm = {exm[30:0], fbit(w3[j], k, 1'b1)};
      end
    check("three_lsb_bits", sl, exl);
    check("three_msb_bits", sm, exm);
    check("three_contig", nv, 3 * FL);
    repeat (4) @(negedge clk);
    check("three_done", {30'd0, l_busy, l_valid}, 32'd0);

    // Reset in the middle of a 0xFF frame
    @(posedge clk); #2;
    din = 8'hFF; din_valid = 1'b1;
    @(posedge clk); #2 din_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_idle", {26'd0, l_valid, l_busy, l_ready, l_out, m_valid, m_busy}, 32'd0);
    #1 rst = 1'b1;
    @(posedge clk); #2;
    check("abort_ready", {30'd0, l_ready, m_ready}, 32'd3);
    nv = 0;
    repeat (12) begin
      @(negedge clk);
      if (l_valid || m_valid) nv++;
    end
    check("abort_no_resume", nv, 0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      din       = 8'($urandom);
      din_valid = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 249) != 0);
    end
    @(posedge clk); #2;
    din_valid = 1'b0; rst = 1'b1;
    repeat (3 * FL + 5) @(posedge clk);
    @(negedge clk);
    check("final_idle", {30'd0, l_busy, m_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
